// File: rtl/mux_pkg.sv
// Shared types and defaults for the stream selector and its arbiter.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_NUM_IN = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or after
// ptr (scanning upward, wrapping) wins. The pointer itself lives in the caller.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_IN = DEFAULT_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any_grant
);

  // Scan from the farthest offset down to offset 0 so the closest requester
  // to ptr is written last and therefore wins. SEL_W-bit addition wraps
  // modulo NUM_IN because NUM_IN is a power of two.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        grant                     = '0;
        grant[ptr + SEL_W'(k)]    = 1'b1;
        grant_idx                 = ptr + SEL_W'(k);
        any_grant                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-input valid/ready stream selector with a one-entry registered output.
// Selects by explicit sel (fixed mode) or by fair round-robin (RR mode).
module stream_mux
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = DEFAULT_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  logic [SEL_W-1:0]  ptr;
  logic [NUM_IN-1:0] arb_grant;
  logic [SEL_W-1:0]  arb_idx;
  logic              arb_any;
  logic [NUM_IN-1:0] sel_onehot;
  logic [SEL_W-1:0]  cand;
  logic [WIDTH-1:0]  cand_data;
  logic              is_rr;
  logic              load_en;
  logic              transfer;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  assign is_rr = (mode_e'(mode) == MODE_RR);

  // Reset blocks acceptance immediately so no input sees ready while held.
  assign load_en = !reset && (!out_valid || out_ready);

  // In fixed mode ready follows sel regardless of valid; in RR mode it
  // follows the arbiter grant, which is empty when nobody requests.
  always_comb begin
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
    in_ready        = '0;
    if (load_en) in_ready = is_rr ? arb_grant : sel_onehot;
  end

  assign transfer = |(in_ready & in_valid);
  assign cand     = is_rr ? arb_idx : sel;

  // Extract the candidate's word from the packed input bus.
  always_comb begin
    cand_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (SEL_W'(i) == cand) cand_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register and RR pointer: load on transfer, clear valid on a bare
  // drain, hold everything otherwise (including the stall case).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      if (transfer) begin
        out_valid <= 1'b1;
        out_data  <= cand_data;
        out_src   <= cand;
        if (is_rr) ptr <= cand + SEL_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // arb_any is implied by a non-empty grant; tie it off explicitly.
  logic unused_ok;
  assign unused_ok = arb_any;

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: a transaction-level model tracks the
// 4-input instance every cycle; directed literals pin key points and an
// 8-input/16-bit instance is swept in fixed mode.
module tb_stream_mux;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- 4 x 32 instance ----------------
  logic [127:0] in_data4  = '0;
  logic [3:0]   in_valid4 = '0;
  logic [3:0]   in_ready4;
  logic [1:0]   sel4      = '0;
  logic         mode4     = 1'b0;
  logic [31:0]  out_data4;
  logic         out_valid4;
  logic         out_ready4 = 1'b0;
  logic [1:0]   out_src4;

  stream_mux #(.WIDTH(32), .NUM_IN(4)) dut4 (
    .clk(clk), .reset(reset), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .sel(sel4), .mode(mode4), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_src(out_src4)
  );

  // ---------------- 8 x 16 instance ----------------
  logic [127:0] in_data8  = '0;
  logic [7:0]   in_valid8 = '0;
  logic [7:0]   in_ready8;
  logic [2:0]   sel8      = '0;
  logic         mode8     = 1'b0;
  logic [15:0]  out_data8;
  logic         out_valid8;
  logic         out_ready8 = 1'b0;
  logic [2:0]   out_src8;

  stream_mux #(.WIDTH(16), .NUM_IN(8)) dut8 (
    .clk(clk), .reset(reset), .in_data(in_data8), .in_valid(in_valid8),
    .in_ready(in_ready8), .sel(sel8), .mode(mode8), .out_data(out_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_src(out_src8)
  );

  // ---------------- model of the 4-input instance ----------------
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic [1:0]  m_src   = '0;
  int          m_ptr   = 0;
  logic        cmp_en  = 1'b0;

  // Which input the rules say may move this cycle (-1 if none is offered).
  function automatic int m_cand();
    if (mode4 == 1'b0) return int'(sel4);
    for (int k = 0; k < 4; k++)
      if (in_valid4[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int c;
    c = m_cand();
    if (reset || (m_valid && !out_ready4) || c < 0) return 4'b0000;
    return 4'b0001 << c;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= '0;
      m_ptr   <= 0;
    end else if (|(m_ready() & in_valid4)) begin
      m_valid <= 1'b1;
      m_data  <= in_data4[m_cand()*32 +: 32];
      m_src   <= 2'(m_cand());
      if (mode4) m_ptr <= (m_cand() + 1) % 4;
    end else if (m_valid && out_ready4) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_out_valid", 64'(out_valid4), 64'(m_valid));
      check("m_out_data",  64'(out_data4),  64'(m_data));
      check("m_out_src",   64'(out_src4),   64'(m_src));
      check("m_in_ready",  64'(in_ready4),  64'(m_ready()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input int i, input logic [31:0] w);
    in_data4[i*32 +: 32] = w;
  endtask

  localparam logic [1:0] RR_SRC [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

  initial begin
    step();
    step();
    check("rst_valid", 64'(out_valid4), 64'(0));
    check("rst_data",  64'(out_data4),  64'(0));
    check("rst_src",   64'(out_src4),   64'(0));
    check("rst_ready", 64'(in_ready4),  64'(0));
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Fixed mode, sel=2.
    set4(0, 32'h1111_1111); set4(1, 32'h2222_2222);
    set4(2, 32'hDEAD_BEEF); set4(3, 32'h4444_4444);
    mode4 = 1'b0; sel4 = 2'd2; in_valid4 = 4'b0100; out_ready4 = 1'b1;
    #2 check("fix_ready", 64'(in_ready4), 64'(4'b0100));
    step();
    check("fix_valid", 64'(out_valid4), 64'(1));
    check("fix_data",  64'(out_data4),  64'(32'hDEAD_BEEF));
    check("fix_src",   64'(out_src4),   64'(2));

    // Stall three cycles while inputs churn.
    out_ready4 = 1'b0; in_valid4 = 4'b1111; sel4 = 2'd1;
    for (int c = 0; c < 3; c++) begin
      set4(c, 32'h5000_0000 + 32'(c)); set4(2, 32'h6000_0000 + 32'(c));
      #2;
      check("stall_ready", 64'(in_ready4), 64'(0));
      check("stall_data",  64'(out_data4), 64'(32'hDEAD_BEEF));
      check("stall_src",   64'(out_src4),  64'(2));
      step();
    end

    // Release: back-to-back replacement with no bubble.
    out_ready4 = 1'b1; set4(1, 32'hCAFE_0001);
    #2 check("rel_ready", 64'(in_ready4), 64'(4'b0010));
    step();
    check("rel_data", 64'(out_data4), 64'(32'hCAFE_0001));
    check("rel_src",  64'(out_src4),  64'(1));
    sel4 = 2'd3; set4(3, 32'hCAFE_0003);
    step();
    check("b2b_valid", 64'(out_valid4), 64'(1));
    check("b2b_data",  64'(out_data4),  64'(32'hCAFE_0003));

    // Fixed mode offers ready on sel even with nothing valid; drain empties.
    in_valid4 = 4'b0000;
    #2 check("fix_ready_novalid", 64'(in_ready4), 64'(4'b1000));
    step();
    check("drain_valid", 64'(out_valid4), 64'(0));
    check("drain_data",  64'(out_data4),  64'(32'hCAFE_0003));

    // RR with all inputs valid: 0,1,2,3,0 then on to ptr=3.
    mode4 = 1'b1; in_valid4 = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      step();
      check("rr_all_src", 64'(out_src4), 64'(RR_SRC[c]));
    end

    // ptr=3, only inputs 0 and 1 valid: 0,1,0.
    in_valid4 = 4'b0011;
    #2 check("rr_skip_ready", 64'(in_ready4), 64'(4'b0001));
    step(); check("rr_skip_src0", 64'(out_src4), 64'(0));
    step(); check("rr_skip_src1", 64'(out_src4), 64'(1));
    step(); check("rr_skip_src2", 64'(out_src4), 64'(0));

    // Load a word, stall, then reset mid-cycle.
    in_valid4 = 4'b0100; set4(2, 32'h7777_0002);
    step();
    check("pre_rst_src", 64'(out_src4), 64'(2));
    out_ready4 = 1'b0;
    step();
    #1 reset = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid4), 64'(0));
    check("arst_data",  64'(out_data4),  64'(0));
    check("arst_ready", 64'(in_ready4),  64'(0));
    #1 reset = 1'b0;
    in_valid4 = 4'b1111; out_ready4 = 1'b1;
    #1 check("post_rst_ready", 64'(in_ready4), 64'(4'b0001));
    step();
    check("post_rst_src", 64'(out_src4), 64'(0));
    step();
    check("post_rst_src2", 64'(out_src4), 64'(1));
    cmp_en = 1'b0;

    // 8 x 16 fixed-mode sweep.
    for (int i = 0; i < 8; i++) in_data8[i*16 +: 16] = 16'hA000 + 16'(i * 16'h0111);
    in_valid8 = 8'hFF; out_ready8 = 1'b1; mode8 = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel8 = 3'(s);
      #2 check("w8_ready", 64'(in_ready8), 64'(8'b0000_0001 << s));
      step();
      check("w8_valid", 64'(out_valid8), 64'(1));
      check("w8_data",  64'(out_data8),  64'(16'hA000 + 16'(s * 16'h0111)));
      check("w8_src",   64'(out_src8),   64'(s));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
